// File: rtl/nibble_serial_pkg.sv
// Shared types and helpers for the nibble-serial adder slice.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/carry_slice4.sv
// Combinational 4-bit carry slice; also exposes the carry into bit 3 for overflow detection.
module carry_slice4
    import nibble_serial_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                CIN,
    output logic [NIBBLE_W-1:0] S,
    output logic                COUT,
    output logic                C3
);

    logic [3:0] low3;
    logic [1:0] top;

    // Split at bit 3 so the MSB carry-in is directly observable.
    assign low3 = {1'b0, A[2:0]} + {1'b0, B[2:0]} + {3'b000, CIN};
    assign C3   = low3[3];
    assign top  = {1'b0, A[3]} + {1'b0, B[3]} + {1'b0, C3};

    assign S    = {top[0], low3[2:0]};
    assign COUT = top[1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-beat A+B+CIN adder, one nibble per beat LSB first, with a 1-deep valid/ready output register.
// Define SERIAL_ADDER_OVF_EN to register signed overflow on the final beat.
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                CIN_INIT,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [NIBBLE_W-1:0] S,
    output logic                OUT_LAST,
    output logic                COUT,
    output logic                OVF,
    output logic                BUSY
);

    localparam int             CW       = cnt_w(NIBBLES);
    localparam logic [CW-1:0]  LAST_CNT = CW'(NIBBLES - 1);

    state_t                state;
    logic                  carry;
    logic [CW-1:0]         cnt;
    logic [NIBBLE_W-1:0]   sum;
    logic                  c_out;
    logic                  c3;
    logic                  accept;
    logic                  is_last;

    carry_slice4 u_slice (
        .A    (A),
        .B    (B),
        .CIN  (carry),
        .S    (sum),
        .COUT (c_out),
        .C3   (c3)
    );

    assign IN_READY = (state == ST_RUN) && (!OUT_VALID || OUT_READY);
    assign accept   = IN_VALID && IN_READY;
    assign is_last  = (cnt == LAST_CNT);
    assign BUSY     = (state == ST_RUN);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            carry     <= 1'b0;
            cnt       <= '0;
            S         <= '0;
            COUT      <= 1'b0;
            OUT_LAST  <= 1'b0;
            OUT_VALID <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        carry <= CIN_INIT;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        carry <= c_out;
                        if (is_last) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Output register: a new beat overwrites a draining one, so throughput is one per cycle.
            if (accept) begin
                S         <= sum;
                COUT      <= c_out;
                OUT_LAST  <= is_last;
                OUT_VALID <= 1'b1;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVF <= 1'b0;
        end else if (accept) begin
            OVF <= is_last && (c3 ^ c_out);
        end
    end
`else
    logic unused_c3;
    assign unused_c3 = c3;
    assign OVF       = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder against a wide-arithmetic reference model.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic       CIN_INIT;
    logic       IN_VALID;
    logic       IN_READY;
    logic [3:0] A;
    logic [3:0] B;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [3:0] S;
    logic       OUT_LAST;
    logic       COUT;
    logic       OVF;
    logic       BUSY;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .CIN_INIT  (CIN_INIT),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .S         (S),
        .OUT_LAST  (OUT_LAST),
        .COUT      (COUT),
        .OVF       (OVF),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: expected sum nibble, per-beat carry and final signed overflow from plain wide arithmetic.
    function automatic logic [3:0] ref_s(input logic [63:0] a, input logic [63:0] b, input logic cin, input int k);
        logic [63:0] full;
        full = a + b + 64'(cin);
        return full[4*k +: 4];
    endfunction

    function automatic logic ref_cout(input logic [63:0] a, input logic [63:0] b, input logic cin, input int k);
        logic [63:0] mask;
        logic [63:0] part;
        mask = (64'd1 << (4*(k+1))) - 64'd1;
        part = (a & mask) + (b & mask) + 64'(cin);
        return part[4*(k+1)];
    endfunction

    function automatic logic ref_ovf(input logic [63:0] a, input logic [63:0] b, input logic cin, input int k);
        logic [63:0] full;
`ifdef SERIAL_ADDER_OVF_EN
        full = a + b + 64'(cin);
        return (k == N-1) && (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
`else
        full = '0;
        return full[0] & (k == N-1);
`endif
    endfunction

    // One operation: optional stall after beat stall_k, optional START pulse mid-run,
    // optional reset after abort_after accepted beats.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int stall_k, input int stall_cycles,
                          input bit start_mid, input int abort_after);
        logic [63:0] aw;
        logic [63:0] bw;
        int t;
        aw = 64'(a);
        bw = 64'(b);
        @(negedge CLK);
        START    = 1'b1;
        CIN_INIT = cin;
        @(posedge CLK);
        #1;
        START    = 1'b0;
        chk("busy_after_start", BUSY, 1);
        for (int k = 0; k < N; k++) begin
            if (k == abort_after) begin
                RST = 1'b1;
                #1;
                chk("rst_out_valid", OUT_VALID, 0);
                chk("rst_s", S, 0);
                chk("rst_cout", COUT, 0);
                chk("rst_busy", BUSY, 0);
                IN_VALID = 1'b0;
                @(negedge CLK);
                RST = 1'b0;
                return;
            end
            A        = a[4*k +: 4];
            B        = b[4*k +: 4];
            IN_VALID = 1'b1;
            START    = start_mid && (k == 2);
            t = 0;
            while (!IN_READY && t < 20) begin
                @(negedge CLK);
                t++;
            end
            chk("in_ready_wait", IN_READY, 1);
            @(posedge CLK);
            #1;
            START = 1'b0;
            if (k == N-1) IN_VALID = 1'b0;
            chk("beat_s", S, ref_s(aw, bw, cin, k));
            chk("beat_cout", COUT, ref_cout(aw, bw, cin, k));
            chk("beat_last", OUT_LAST, (k == N-1));
            chk("beat_ovf", OVF, ref_ovf(aw, bw, cin, k));
            chk("beat_valid", OUT_VALID, 1);
            if (k == stall_k && stall_cycles > 0) begin
                OUT_READY = 1'b0;
                for (int c = 0; c < stall_cycles; c++) begin
                    @(posedge CLK);
                    #1;
                    chk("stall_s", S, ref_s(aw, bw, cin, k));
                    chk("stall_valid", OUT_VALID, 1);
                    chk("stall_in_ready", IN_READY, 0);
                end
                OUT_READY = 1'b1;
            end
        end
        chk("idle_after_last", BUSY, 0);
        @(posedge CLK);
        #1;
        chk("drained", OUT_VALID, 0);
    endtask

    initial begin
        RST       = 1'b1;
        START     = 1'b0;
        CIN_INIT  = 1'b0;
        IN_VALID  = 1'b0;
        A         = '0;
        B         = '0;
        OUT_READY = 1'b1;
        #3;
        chk("reset_valid", OUT_VALID, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_s", S, 0);
        chk("reset_last", OUT_LAST, 0);
        chk("reset_ovf", OVF, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        run_op(16'h1234, 16'h0FFF, 1'b0, -1, 0, 1'b0, N);
        run_op(16'hFFFF, 16'h0000, 1'b1, -1, 0, 1'b0, N);
        run_op(16'h1234, 16'h0FFF, 1'b0, 0, 3, 1'b0, N);
        run_op(16'h1234, 16'h0FFF, 1'b0, -1, 0, 1'b0, 2);
        run_op(16'h0001, 16'h0001, 1'b0, -1, 0, 1'b0, N);
        run_op(16'h1234, 16'h0FFF, 1'b0, -1, 0, 1'b1, N);

        // IN_VALID while idle must be ignored.
        @(negedge CLK);
        IN_VALID = 1'b1;
        A = 4'hA;
        B = 4'h5;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("idle_in_ready", IN_READY, 0);
            chk("idle_out_valid", OUT_VALID, 0);
            chk("idle_busy", BUSY, 0);
        end
        IN_VALID = 1'b0;

        run_op(16'h7FFF, 16'h0001, 1'b0, -1, 0, 1'b0, N);
        run_op(16'h8000, 16'h8000, 1'b0, -1, 0, 1'b0, N);

        for (int r = 0; r < 12; r++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, N-1)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), N);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
